i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_bus_sync.sv | 40 ++++
 rtl/i2c_target.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and bus widths.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam int I2C_CNT_W  = 4;

  // Bit counter load value at the start of every byte.
  localparam logic [I2C_CNT_W-1:0] I2C_BIT_CNT_LOAD = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACK,
    WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the i_clk domain and flags START, STOP and SCL edges.
// Each line goes through two synchronizer flops plus one history flop, so the
// edge flags are acted on three i_clk edges after the pad changes.
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic i_clk,
  input  logic i_nrst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0] first sync flop, [1] second sync flop, [2] history
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // Synchronizer and history shift registers; an idle bus reads high.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  // SDA may only move while SCL is high for a bus condition.
  assign start_det =  sda_q[2] & ~sda_q[1] & scl_q[1] & scl_q[2];
  assign stop_det  = ~sda_q[2] &  sda_q[1] & scl_q[1] & scl_q[2];

endmodule

// File: rtl/i2c_target.sv
// I2C target with a fixed 7-bit address. Receives write data bytes and, when
// I2C_TARGET_READ_EN is defined, returns i_tx_data on reads. Without
// I2C_TARGET_READ_EN a read to our address is NACKed.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | bus free or not yet started
// ADDR      | shifting in the address byte (7-bit address + R/W)
// ADDR_ACK  | holding SDA low for the address ACK bit
// RX_BYTE   | shifting in a write data byte
// RX_ACK    | holding SDA low for the data ACK bit
// TX_BYTE   | driving a read data byte, MSB first
// TX_ACK    | SDA released, sampling the controller's ACK/NACK
// WAIT_STOP | not addressed or finished; ignore bus until START/STOP
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] OWN_ADDR = 7'h42
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  inout  tri                    io_scl,
  inout  tri                    io_sda,
  input  logic [I2C_BYTE_W-1:0] i_tx_data,
  output logic [I2C_BYTE_W-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_tx_req,
  output logic                  o_busy,
  output logic                  o_stop
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .i_clk     (i_clk),
    .i_nrst    (i_nrst),
    .scl       (io_scl),
    .sda       (io_sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e state_q, state_d;
  logic [I2C_CNT_W-1:0]  cnt_q, cnt_d;
  logic [I2C_BYTE_W-1:0] sr_q, sr_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic sda_oe_q, sda_oe_d;
  logic rx_valid_q, rx_valid_d;
  logic busy_q, busy_d;
  logic stop_q, stop_d;
  logic addr_hit;

`ifdef I2C_TARGET_READ_EN
  logic [I2C_BYTE_W-1:0] txsr_q, txsr_d;
  logic tx_req_q, tx_req_d;
  assign addr_hit = (sr_q[7:1] == OWN_ADDR);
  assign o_tx_req = tx_req_q;
`else
  // Reads are not supported: only a write to our address is acknowledged.
  logic unused_tx;
  assign unused_tx = ^i_tx_data;
  assign addr_hit  = (sr_q[7:1] == OWN_ADDR) && !sr_q[0];
  assign o_tx_req  = 1'b0;
`endif

  // Next-state and next-output logic; STOP beats START beats bit handling.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    rx_data_d  = rx_data_q;
    sda_oe_d   = sda_oe_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    stop_d     = 1'b0;
`ifdef I2C_TARGET_READ_EN
    txsr_d     = txsr_q;
    tx_req_d   = 1'b0;
`endif
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      stop_d   = 1'b1;
    end else if (start_det) begin
      // o_busy is kept across a repeated START and re-decided by the new
      // address, so a continued transfer to us never shows a gap.
      state_d  = ADDR;
      cnt_d    = I2C_BIT_CNT_LOAD;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise && cnt_q != '0) begin
            sr_d  = {sr_q[6:0], sda_s};
            cnt_d = cnt_q - 1'b1;
          end else if (scl_fall && cnt_q == '0) begin
            if (addr_hit) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = I2C_BIT_CNT_LOAD;
            state_d  = RX_BYTE;
`ifdef I2C_TARGET_READ_EN
            if (sr_q[0]) begin
              // The ACK-ending fall also launches the first read bit.
              txsr_d   = {i_tx_data[6:0], 1'b1};
              sda_oe_d = ~i_tx_data[7];
              cnt_d    = 4'd7;
              tx_req_d = 1'b1;
              state_d  = TX_BYTE;
            end
`endif
          end
        end
        RX_BYTE: begin
          if (scl_rise && cnt_q != '0) begin
            sr_d  = {sr_q[6:0], sda_s};
            cnt_d = cnt_q - 1'b1;
          end else if (scl_fall && cnt_q == '0) begin
            rx_data_d  = sr_q;
            rx_valid_d = 1'b1;
            sda_oe_d   = 1'b1;
            state_d    = RX_ACK;
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = I2C_BIT_CNT_LOAD;
            state_d  = RX_BYTE;
          end
        end
`ifdef I2C_TARGET_READ_EN
        TX_BYTE: begin
          if (scl_fall) begin
            if (cnt_q != '0) begin
              sda_oe_d = ~txsr_q[7];
              txsr_d   = {txsr_q[6:0], 1'b1};
              cnt_d    = cnt_q - 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = TX_ACK;
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              txsr_d   = i_tx_data;
              cnt_d    = I2C_BIT_CNT_LOAD;
              tx_req_d = 1'b1;
              state_d  = TX_BYTE;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
`endif
        IDLE, WAIT_STOP: begin
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      rx_data_q  <= '0;
      sda_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      stop_q     <= 1'b0;
`ifdef I2C_TARGET_READ_EN
      txsr_q     <= '0;
      tx_req_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      rx_data_q  <= rx_data_d;
      sda_oe_q   <= sda_oe_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      stop_q     <= stop_d;
`ifdef I2C_TARGET_READ_EN
      txsr_q     <= txsr_d;
      tx_req_q   <= tx_req_d;
`endif
    end
  end

  assign io_sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_busy     = busy_q;
  assign o_stop     = stop_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bus controller model drives transactions and the
// results are compared with what the I2C protocol says the target must do.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int Q = 10;   // quarter SCL period in i_clk cycles

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic rx_valid, tx_req, busy, stop;
  wire scl_bus, sda_bus;

  assign scl_bus = m_scl;
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_target #(.OWN_ADDR(7'h42)) dut (
    .i_clk(clk), .i_nrst(nrst), .io_scl(scl_bus), .io_sda(sda_bus),
    .i_tx_data(tx_data), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .o_tx_req(tx_req), .o_busy(busy), .o_stop(stop)
  );

  int n_tests = 0;
  int n_fail = 0;

  // bus/output monitor
  logic [7:0] rx_q[$];
  int n_tx, n_stop, n_pull, n_busy_hi, n_busy_drop;
  logic watch_busy = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_req) n_tx++;
    if (stop) n_stop++;
    if (sda_bus === 1'b0 && !m_sda_low) n_pull++;
    if (busy) n_busy_hi++;
    if (watch_busy && !busy) n_busy_drop++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr_mon();
    rx_q.delete();
    n_tx = 0; n_stop = 0; n_pull = 0; n_busy_hi = 0; n_busy_drop = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  // START or repeated START; leaves SCL low
  task automatic bus_start();
    tick(Q); m_sda_low = 1'b0;
    tick(Q); m_scl = 1'b1;
    tick(Q); m_sda_low = 1'b1;
    tick(Q); m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); m_sda_low = 1'b1;
    tick(Q); m_scl = 1'b1;
    tick(Q); m_sda_low = 1'b0;
    tick(2*Q);
  endtask

  task automatic send_bit(input logic b);
    tick(Q); m_sda_low = ~b;
    tick(Q); m_scl = 1'b1;
    tick(2*Q); m_scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    tick(Q); m_sda_low = 1'b0;
    tick(Q); m_scl = 1'b1;
    tick(Q); #1 b = sda_bus;
    tick(Q); m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = (b === 1'b0);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tick(3); #1;
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    n_tests++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req got %b want 0", tx_req); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (stop !== 1'b0) begin n_fail++; $display("FAIL reset_stop got %b want 0", stop); end
    n_tests++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL reset_sda got %b want 1", sda_bus); end
    nrst = 1'b1;
    tick(5);
  endtask

  task automatic test_write();
    logic [7:0] exp_q[$];
    logic ack;
    for (int pass = 0; pass < 2; pass++) begin
      clr_mon();
      exp_q.delete();
      if (pass == 0) begin
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
      end else begin
        repeat (3) exp_q.push_back(8'($urandom));
      end
      bus_start();
      write_byte({7'h42, 1'b0}, ack);
      n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL write_addr_ack got %b want 1", ack); end
      #1;
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy got %b want 1", busy); end
      foreach (exp_q[i]) begin
        write_byte(exp_q[i], ack);
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL write_data_ack byte %0d got %b want 1", i, ack); end
      end
      bus_stop();
      #1;
      n_tests++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL write_rx_count got %0d want %0d", rx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        if (i < rx_q.size()) begin
          n_tests++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL write_rx_data byte %0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
      end
      n_tests++; if (n_stop != 1) begin n_fail++; $display("FAIL write_stop_pulses got %0d want 1", n_stop); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop got %b want 0", busy); end
      n_tests++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL write_sda_released got %b want 1", sda_bus); end
    end
  endtask

  task automatic test_wrong_addr();
    logic [6:0] a;
    logic rw, ack;
    clr_mon();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) a = 7'h17;
      else begin
        do a = 7'($urandom); while (a == 7'h42);
      end
      rw = (k == 0) ? 1'b0 : 1'($urandom);
      bus_start();
      write_byte({a, rw}, ack);
      n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_ack addr %h got %b want 0", a, ack); end
      write_byte(8'($urandom), ack);
      n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_data_ack addr %h got %b want 0", a, ack); end
      bus_stop();
    end
    n_tests++; if (n_pull != 0) begin n_fail++; $display("FAIL wrong_addr_pulldown got %0d cycles want 0", n_pull); end
    n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL wrong_addr_rx_valid got %0d want 0", rx_q.size()); end
    n_tests++; if (n_busy_hi != 0) begin n_fail++; $display("FAIL wrong_addr_busy got %0d cycles want 0", n_busy_hi); end
    n_tests++; if (n_stop != 3) begin n_fail++; $display("FAIL wrong_addr_stop_pulses got %0d want 3", n_stop); end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d, d2, a, b;
`ifdef I2C_TARGET_READ_EN
    clr_mon();
    tx_data = 8'h81;
    bus_start();
    write_byte({7'h42, 1'b1}, ack);
    n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL read_addr_ack got %b want 1", ack); end
    read_byte(d);
    n_tests++; if (d !== 8'h81) begin n_fail++; $display("FAIL read_byte0 got %h want 81", d); end
    send_bit(1'b0);
    read_byte(d);
    n_tests++; if (d !== 8'h81) begin n_fail++; $display("FAIL read_byte1 got %h want 81", d); end
    send_bit(1'b1);
    read_byte(d);
    n_tests++; if (d !== 8'hFF) begin n_fail++; $display("FAIL read_after_nack got %h want ff", d); end
    send_bit(1'b1);
    bus_stop();
    n_tests++; if (n_tx != 2) begin n_fail++; $display("FAIL read_tx_req_pulses got %0d want 2", n_tx); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_after_stop got %b want 0", busy); end
    clr_mon();
    a = 8'($urandom); b = 8'($urandom);
    tx_data = a;
    bus_start();
    write_byte({7'h42, 1'b1}, ack);
    read_byte(d);
    tx_data = b;
    send_bit(1'b0);
    read_byte(d2);
    send_bit(1'b1);
    bus_stop();
    n_tests++; if (d !== a) begin n_fail++; $display("FAIL read_rand0 got %h want %h", d, a); end
    n_tests++; if (d2 !== b) begin n_fail++; $display("FAIL read_rand1 got %h want %h", d2, b); end
    n_tests++; if (n_tx != 2) begin n_fail++; $display("FAIL read_rand_tx_req got %0d want 2", n_tx); end
`else
    clr_mon();
    tx_data = 8'($urandom);
    bus_start();
    write_byte({7'h42, 1'b1}, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL read_disabled_addr_ack got %b want 0", ack); end
    read_byte(d);
    n_tests++; if (d !== 8'hFF) begin n_fail++; $display("FAIL read_disabled_data got %h want ff", d); end
    send_bit(1'b1);
    bus_stop();
    n_tests++; if (n_tx != 0) begin n_fail++; $display("FAIL read_disabled_tx_req got %0d want 0", n_tx); end
    n_tests++; if (n_pull != 0) begin n_fail++; $display("FAIL read_disabled_pulldown got %0d want 0", n_pull); end
    n_tests++; if (n_busy_hi != 0) begin n_fail++; $display("FAIL read_disabled_busy got %0d want 0", n_busy_hi); end
`endif
  endtask

  task automatic test_abort_mid_byte();
    logic ack;
    logic [7:0] d, d2;
    clr_mon();
    bus_start();
    write_byte({7'h42, 1'b0}, ack);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    bus_stop();
    #1;
    n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL stop_mid_rx_valid got %0d want 0", rx_q.size()); end
    n_tests++; if (n_stop != 1) begin n_fail++; $display("FAIL stop_mid_stop_pulses got %0d want 1", n_stop); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_mid_busy got %b want 0", busy); end
    n_tests++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL stop_mid_sda got %b want 1", sda_bus); end
    d = 8'($urandom); d2 = 8'($urandom);
    bus_start();
    write_byte({7'h42, 1'b0}, ack);
    write_byte(d, ack);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    bus_start();
    write_byte({7'h42, 1'b0}, ack);
    write_byte(d2, ack);
    bus_stop();
    n_tests++; if (rx_q.size() != 2) begin n_fail++; $display("FAIL abort_recover_count got %0d want 2", rx_q.size()); end
    if (rx_q.size() == 2) begin
      n_tests++; if (rx_q[0] !== d) begin n_fail++; $display("FAIL abort_recover_byte0 got %h want %h", rx_q[0], d); end
      n_tests++; if (rx_q[1] !== d2) begin n_fail++; $display("FAIL abort_recover_byte1 got %h want %h", rx_q[1], d2); end
    end
  endtask

  task automatic test_back_to_back();
    logic ack0, ack1, ack2, ack3;
    clr_mon();
    bus_start();
    write_byte({7'h42, 1'b0}, ack0);
    watch_busy = 1'b1;
    write_byte(8'h11, ack1);
    bus_start();
    write_byte({7'h42, 1'b0}, ack2);
    write_byte(8'h22, ack3);
    watch_busy = 1'b0;
    bus_stop();
    n_tests++; if ({ack0, ack1, ack2, ack3} !== 4'b1111) begin n_fail++; $display("FAIL rstart_acks got %b want 1111", {ack0, ack1, ack2, ack3}); end
    n_tests++; if (rx_q.size() != 2) begin n_fail++; $display("FAIL rstart_rx_count got %0d want 2", rx_q.size()); end
    if (rx_q.size() == 2) begin
      n_tests++; if (rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22) begin n_fail++; $display("FAIL rstart_rx_data got %h %h want 11 22", rx_q[0], rx_q[1]); end
    end
    n_tests++; if (n_busy_drop != 0) begin n_fail++; $display("FAIL rstart_busy_drop got %0d cycles want 0", n_busy_drop); end
    n_tests++; if (n_stop != 1) begin n_fail++; $display("FAIL rstart_stop_pulses got %0d want 1", n_stop); end
  endtask

  task automatic test_reset_in_ack();
    logic [7:0] a;
    clr_mon();
    a = {7'h42, 1'b0};
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    tick(Q); m_sda_low = 1'b0;
    tick(2); #1;
    n_tests++; if (sda_bus !== 1'b0) begin n_fail++; $display("FAIL ack_driven_before_reset got %b want 0", sda_bus); end
    nrst = 1'b0;
    #1;
    n_tests++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL reset_in_ack_sda got %b want 1", sda_bus); end
    n_tests++; if ({rx_data, rx_valid, tx_req, busy, stop} !== 12'h000) begin
      n_fail++; $display("FAIL reset_in_ack_outputs got %h want 000", {rx_data, rx_valid, tx_req, busy, stop});
    end
    tick(3);
    nrst = 1'b1;
    tick(3);
    bus_stop();
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_abort_mid_byte();
    test_back_to_back();
    test_reset_in_ack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
